gor_bist: RTL and testbench

Self-test driver and checker for the two-input gate cells (`gor` and its siblings). It is the hardware counterpart of the gate stimulus bench. On `start` it drives all four `a`/`b` input combinations into the gate under test in Gray order, holding each for a configurable number of cycles. It samples the gate output `y` at the end of each hold, compares it against the expected truth table and reports an error count and a pass flag.

---
 rtl/gor_bist.sv | 142 ++++++++++++++
 tb/tb_gor_bist.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gor_bist.sv
// gor_bist: built-in self-test driver and checker for two-input gate cells.
// Walks the four a/b combinations in Gray order, holds each for HOLD_CYCLES,
// checks y against the selected truth table and reports errors and pass.
module gor_bist #(
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic [1:0]       vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       func_q, func_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [1:0]       vec_nxt, vec_inc;
  logic [ERR_W-1:0] err_nxt, err_chk;

  // Truth table of the gate type the run is checking.
  function automatic logic expected_y(input logic [1:0] f, input logic ia, input logic ib);
    case (f)
      2'b00:   return ia | ib;
      2'b01:   return ia & ib;
      2'b10:   return ia ^ ib;
      default: return ~(ia | ib);
    endcase
  endfunction

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
    if (e == {ERR_W{1'b1}}) return e;
    return e + ERR_W'(1);
  endfunction

  // Gray-ordered vector table: 00, 10, 11, 01.
  function automatic logic gray_a(input logic [1:0] v);
    return v[1] ^ v[0];
  endfunction

  function automatic logic gray_b(input logic [1:0] v);
    return v[1];
  endfunction

  // Next-state and next-output logic; everything defaults to holding its value.
  always_comb begin
    state_nxt = state;
    func_nxt  = func_q;
    hold_nxt  = hold_cnt;
    a_nxt     = a;
    b_nxt     = b;
    vec_nxt   = vec;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    err_nxt   = err_count;
    vec_inc   = vec + 2'd1;
    err_chk   = (y != expected_y(func_q, a, b)) ? sat_inc(err_count) : err_count;

    case (state)
      IDLE: begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = RUN;
          func_nxt  = func;
          err_nxt   = '0;
          pass_nxt  = 1'b0;
          vec_nxt   = 2'd0;
          hold_nxt  = HOLD_LOAD;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - CNT_W'(1);
        end else begin
          // Check edge: the final vector's compare is folded into pass.
          err_nxt = err_chk;
          if (vec != 2'd3) begin
            vec_nxt  = vec_inc;
            a_nxt    = gray_a(vec_inc);
            b_nxt    = gray_b(vec_inc);
            hold_nxt = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            vec_nxt   = 2'd0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_chk == '0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      func_q    <= 2'd0;
      hold_cnt  <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      vec       <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      func_q    <= func_nxt;
      hold_cnt  <= hold_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      vec       <= vec_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
    end
  end

endmodule

// File: tb/tb_gor_bist.sv
// Testbench for gor_bist: two instances (H=10/ERR_W=3 and H=1/ERR_W=1),
// a time-based reference model and directed scenarios with literal checks.
module tb_gor_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [1:0] func0 = 2'd0, func1 = 2'd0;
  int         gm0 = 0, gm1 = 0;   // 0: working OR gate, 1: output stuck at 0
  wire        y0, y1;
  wire        a0, b0, busy0, done0, pass0;
  wire        a1, b1, busy1, done1, pass1;
  wire [1:0]  vec0, vec1;
  wire [2:0]  err0;
  wire [0:0]  err1;

  assign y0 = (gm0 == 0) ? (a0 | b0) : 1'b0;
  assign y1 = (gm1 == 0) ? (a1 | b1) : 1'b0;

  gor_bist #(.HOLD_CYCLES(10), .ERR_W(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .func(func0), .y(y0),
    .a(a0), .b(b0), .vec(vec0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0)
  );

  gor_bist #(.HOLD_CYCLES(1), .ERR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .func(func1), .y(y1),
    .a(a1), .b(b1), .vec(vec1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles since the start edge and derives everything
  // from that count, the Gray table and the truth tables.
  int         HH   [2] = '{10, 1};
  int         EMAX [2] = '{7, 1};
  logic [3:0] ga = 4'b0110;   // a of vector k is ga[k]
  logic [3:0] gb = 4'b1100;   // b of vector k is gb[k]
  logic [3:0] tt [4] = '{4'b1110, 4'b1000, 4'b0110, 4'b0001};  // OR, AND, XOR, NOR by {a,b}

  bit         m_busy [2];
  bit         m_done [2];
  bit         m_pass [2];
  int         m_t    [2];
  int         m_err  [2];
  logic [1:0] m_func [2];

  function automatic logic in_start(int g); return (g == 0) ? start0 : start1; endfunction
  function automatic logic [1:0] in_func(int g); return (g == 0) ? func0 : func1; endfunction
  function automatic logic in_y(int g); return (g == 0) ? y0 : y1; endfunction
  function automatic bit is_chk(int g); return ((m_t[g] + 1) % HH[g]) == 0; endfunction
  function automatic int chk_vec(int g); return (m_t[g] + 1) / HH[g] - 1; endfunction

  function automatic int miss(int g);
    int k;
    k = chk_vec(g);
    return (in_y(g) != tt[m_func[g]][{ga[k], gb[k]}]) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_busy[g] <= 1'b0;
        m_done[g] <= 1'b0;
        m_pass[g] <= 1'b0;
        m_t[g]    <= 0;
        m_err[g]  <= 0;
        m_func[g] <= 2'd0;
      end else begin
        m_done[g] <= 1'b0;
        if (!m_busy[g]) begin
          if (in_start(g)) begin
            m_busy[g] <= 1'b1;
            m_t[g]    <= 0;
            m_func[g] <= in_func(g);
            m_err[g]  <= 0;
            m_pass[g] <= 1'b0;
          end
        end else begin
          m_t[g] <= m_t[g] + 1;
          if (is_chk(g)) begin
            m_err[g] <= m_err[g] + miss(g);
            if (chk_vec(g) == 3) begin
              m_busy[g] <= 1'b0;
              m_done[g] <= 1'b1;
              m_pass[g] <= (m_err[g] + miss(g)) == 0;
            end
          end
        end
      end
    end
  end

  function automatic int e_vec(int g); return m_busy[g] ? m_t[g] / HH[g] : 0; endfunction
  function automatic int e_a(int g); return m_busy[g] ? int'(ga[e_vec(g)]) : 0; endfunction
  function automatic int e_b(int g); return m_busy[g] ? int'(gb[e_vec(g)]) : 0; endfunction
  function automatic int e_err(int g); return (m_err[g] > EMAX[g]) ? EMAX[g] : m_err[g]; endfunction

  // Every-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("dut0.a", a0, e_a(0));
      chk("dut0.b", b0, e_b(0));
      chk("dut0.vec", vec0, e_vec(0));
      chk("dut0.busy", busy0, m_busy[0]);
      chk("dut0.done", done0, m_done[0]);
      chk("dut0.pass", pass0, m_pass[0]);
      chk("dut0.err", err0, e_err(0));
      chk("dut1.a", a1, e_a(1));
      chk("dut1.b", b1, e_b(1));
      chk("dut1.vec", vec1, e_vec(1));
      chk("dut1.busy", busy1, m_busy[1]);
      chk("dut1.done", done1, m_done[1]);
      chk("dut1.pass", pass1, m_pass[1]);
      chk("dut1.err", err1, e_err(1));
    end
  end

  // Pulse start on dut0, optionally re-pulse it mid-run, count edges to done.
  task automatic run0(input logic [1:0] f, input int repulse, output int cyc);
    func0  = f;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    func0  = ~f;
    cyc    = 0;
    while (!done0 && cyc < 200) begin
      start0 = (cyc == repulse);
      @(negedge clk);
      cyc++;
    end
    start0 = 1'b0;
    if (cyc >= 200) chk("run0.timeout", cyc, 40);
  endtask

  initial begin
    int cyc;
    int pulses;
    bit dn;

    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst.a", a0, 0);
    chk("rst.busy", busy0, 0);
    chk("rst.vec", vec0, 0);
    chk("rst.err", err0, 0);
    chk("rst.pass", pass0, 0);
    chk("rst.done", done0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Working OR gate, OR expected: vector timeline and completion.
    gm0 = 0; func0 = 2'b00; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("or.busy.E0", busy0, 1);
    chk("or.ab.E0", {a0, b0}, 0);
    repeat (9) @(negedge clk);
    chk("or.ab.E9", {a0, b0}, 0);
    @(negedge clk);
    chk("or.ab.E10", {a0, b0}, 2);
    chk("or.vec.E10", vec0, 1);
    repeat (10) @(negedge clk);
    chk("or.ab.E20", {a0, b0}, 3);
    repeat (10) @(negedge clk);
    chk("or.ab.E30", {a0, b0}, 1);
    chk("or.vec.E30", vec0, 3);
    repeat (9) @(negedge clk);
    chk("or.done.E39", done0, 0);
    chk("or.busy.E39", busy0, 1);
    @(negedge clk);
    chk("or.done.E40", done0, 1);
    chk("or.busy.E40", busy0, 0);
    chk("or.err", err0, 0);
    chk("or.pass", pass0, 1);
    chk("or.ab.E40", {a0, b0}, 0);
    @(negedge clk);
    chk("or.done.E41", done0, 0);

    // Stuck-at-0 output, OR expected: three mismatches.
    gm0 = 1;
    run0(2'b00, -1, cyc);
    chk("stuck.len", cyc, 40);
    chk("stuck.err", err0, 3);
    chk("stuck.pass", pass0, 0);
    @(negedge clk);
    chk("stuck.single_done", done0, 0);

    // Working OR gate checked as AND: mismatches on vec1 and vec3.
    gm0 = 0;
    run0(2'b01, -1, cyc);
    chk("and.err", err0, 2);
    chk("and.pass", pass0, 0);
    // Checked as XOR: only 11 differs.
    run0(2'b10, -1, cyc);
    chk("xor.err", err0, 1);
    // Checked as NOR: every vector differs.
    run0(2'b11, -1, cyc);
    chk("nor.err", err0, 4);
    chk("nor.pass", pass0, 0);
    @(negedge clk);

    // Start re-pulsed mid-run is ignored; run length stays 4H.
    run0(2'b00, 15, cyc);
    chk("repulse.len", cyc, 40);
    chk("repulse.pass", pass0, 1);
    @(negedge clk);

    // Reset during vec2 with a stuck gate (one error already counted).
    gm0 = 1; func0 = 2'b00; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (25) @(negedge clk);
    chk("midrst.vec", vec0, 2);
    chk("midrst.err", err0, 1);
    rst = 1'b1;
    #1;
    chk("midrst.a", a0, 0);
    chk("midrst.b", b0, 0);
    chk("midrst.vec0", vec0, 0);
    chk("midrst.busy", busy0, 0);
    chk("midrst.err0", err0, 0);
    chk("midrst.pass", pass0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    chk("midrst.no_done", pulses, 0);
    gm0 = 0;
    run0(2'b00, -1, cyc);
    chk("midrst.rerun.len", cyc, 40);
    chk("midrst.rerun.pass", pass0, 1);
    @(negedge clk);

    // H=1, ERR_W=1, start held: back-to-back runs every 5 cycles.
    gm1 = 1; func1 = 2'b00; start1 = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      dn = (n == 4) || (n == 9) || (n == 14);
      chk($sformatf("held.done.n%0d", n), done1, dn);
      chk($sformatf("held.busy.n%0d", n), busy1, !dn);
      if (n == 4) begin
        chk("held.sat.err", err1, 1);
        chk("held.sat.pass", pass1, 0);
        gm1 = 0;
      end
      if (n == 5) begin
        chk("held.clear.err", err1, 0);
        chk("held.clear.pass", pass1, 0);
      end
      if (n == 9) begin
        chk("held.good.err", err1, 0);
        chk("held.good.pass", pass1, 1);
        gm1 = 1;
      end
      if (n == 14) begin
        chk("held.sat2.err", err1, 1);
        chk("held.sat2.pass", pass1, 0);
      end
    end
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("held.idle.busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
